// File: rtl/rx_block.sv
// Receive-only CAN 2.0A deserialiser: synchronises can_rx, destuffs, checks CRC-15, decodes standard frames.
// Latency: can_rx -> sampled bit 2 clk; rx_valid / rx_err one clk after the baud_clk cycle that decides them.
// Backpressure: none; results are single-cycle strobes the host must capture. baud_clk = 0 freezes all state.
//
// Ports:
//   clk, rst (async active-low), baud_clk (one-cycle strobe at the bit sample point), can_rx (raw bus, 0 = dominant)
//   address_rx / rx_dlc / rx_rtr / rx_data : last good frame (payload first byte at [63:56], unused bytes 0)
//   rx_valid / rx_err : one-cycle completion / error strobes; err_code : 1 stuff, 2 CRC, 3 form, 4 IDE=1
//   rxing : high from the SOF sample until the frame completes or aborts
module rx_block #(
    parameter logic [14:0] CRC_POLY  = 15'h4599,
    parameter int          IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_clk,
    input  logic        can_rx,
    output logic [10:0] address_rx,
    output logic [3:0]  rx_dlc,
    output logic        rx_rtr,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        rx_err,
    output logic [2:0]  err_code,
    output logic        rxing
);

    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic [3:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_ID,
        S_CTRL,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK,
        S_EOF
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [IW-1:0] r_idle_cnt;
    logic [2:0]    r_run_cnt;
    logic          r_last_bit;
    logic [14:0]   r_crc;
    logic [14:0]   r_crc_rx;
    logic [6:0]    r_bit_cnt;
    logic [6:0]    r_data_bits;
    logic [10:0]   r_sh_id;
    logic          r_sh_rtr;
    logic [3:0]    r_sh_dlc;
    logic [63:0]   r_sh_data;

    logic          w_bit;
    logic          w_destuff_active;
    logic          w_stuff_slot;
    logic [14:0]   w_crc_next;
    logic [3:0]    w_dlc_full;
    logic [3:0]    w_nbytes;
    logic [6:0]    w_data_bits;
    logic [2:0]    w_err_code;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC_POLY : 15'h0000);
    endfunction

    assign w_bit            = r_sync2;
    assign w_destuff_active = (r_state == S_ID) || (r_state == S_CTRL) ||
                              (r_state == S_DATA) || (r_state == S_CRC);
    // After a run of five equal bits the next line bit is a stuff bit, never payload.
    assign w_stuff_slot     = w_destuff_active && (r_run_cnt == 3'd5);
    assign w_crc_next       = crc_step(r_crc, w_bit);
    // DLC is only complete on the last CTRL bit, so the payload length is formed from the live bit.
    assign w_dlc_full       = {r_sh_dlc[2:0], w_bit};
    assign w_nbytes         = r_sh_rtr ? 4'd0 : ((w_dlc_full > 4'd8) ? 4'd8 : w_dlc_full);
    assign w_data_bits      = {w_nbytes, 3'b000};

    always_comb begin
        w_err_code = 3'd0;
        case (r_state)
            S_ID, S_CTRL, S_DATA, S_CRC: begin
                if (w_stuff_slot) begin
                    if (w_bit == r_last_bit) w_err_code = 3'd1;
                end else if (r_state == S_CTRL && r_bit_cnt == 7'd1 && w_bit) begin
                    w_err_code = 3'd4;
                end else if (r_state == S_CRC && r_bit_cnt == 7'd14 &&
                             {r_crc_rx[13:0], w_bit} != r_crc) begin
                    w_err_code = 3'd2;
                end
            end
            S_CRC_DEL: if (!w_bit) w_err_code = 3'd3;
            S_ACK:     if (r_bit_cnt == 7'd1 && !w_bit) w_err_code = 3'd3;
            S_EOF:     if (!w_bit) w_err_code = 3'd3;
            default:   w_err_code = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_WAIT_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_idle_cnt  <= '0;
            r_run_cnt   <= 3'd0;
            r_last_bit  <= 1'b0;
            r_crc       <= 15'd0;
            r_crc_rx    <= 15'd0;
            r_bit_cnt   <= 7'd0;
            r_data_bits <= 7'd0;
            r_sh_id     <= 11'd0;
            r_sh_rtr    <= 1'b0;
            r_sh_dlc    <= 4'd0;
            r_sh_data   <= 64'd0;
            address_rx  <= 11'd0;
            rx_dlc      <= 4'd0;
            rx_rtr      <= 1'b0;
            rx_data     <= 64'd0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            err_code    <= 3'd0;
            rxing       <= 1'b0;
        end else begin
            r_sync1  <= can_rx;
            r_sync2  <= r_sync1;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (baud_clk) begin
                if (w_err_code != 3'd0) begin
                    rx_err     <= 1'b1;
                    err_code   <= w_err_code;
                    rxing      <= 1'b0;
                    r_state    <= S_WAIT_IDLE;
                    r_idle_cnt <= '0;
                    r_bit_cnt  <= 7'd0;
                end else begin
                    if (w_destuff_active) begin
                        // A valid stuff bit differs from the run, so it also restarts the count at 1.
                        if (w_stuff_slot || w_bit != r_last_bit) r_run_cnt <= 3'd1;
                        else                                     r_run_cnt <= r_run_cnt + 3'd1;
                        r_last_bit <= w_bit;
                    end
                    if (!w_stuff_slot) begin
                        case (r_state)
                            S_WAIT_IDLE: begin
                                if (w_bit) begin
                                    if (r_idle_cnt == IW'(IDLE_BITS - 1)) begin
                                        r_state    <= S_IDLE;
                                        r_idle_cnt <= '0;
                                    end else begin
                                        r_idle_cnt <= r_idle_cnt + 1'b1;
                                    end
                                end else begin
                                    r_idle_cnt <= '0;
                                end
                            end
                            S_IDLE: begin
                                if (!w_bit) begin
                                    r_state    <= S_ID;
                                    rxing      <= 1'b1;
                                    r_run_cnt  <= 3'd1;
                                    r_last_bit <= 1'b0;
                                    r_crc      <= crc_step(15'd0, w_bit);
                                    r_bit_cnt  <= 7'd0;
                                    r_sh_data  <= 64'd0;
                                    r_sh_dlc   <= 4'd0;
                                end
                            end
                            S_ID: begin
                                r_sh_id <= {r_sh_id[9:0], w_bit};
                                r_crc   <= w_crc_next;
                                if (r_bit_cnt == 7'd10) begin
                                    r_state   <= S_CTRL;
                                    r_bit_cnt <= 7'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 7'd1;
                                end
                            end
                            S_CTRL: begin
                                r_crc <= w_crc_next;
                                if (r_bit_cnt == 7'd0) r_sh_rtr <= w_bit;
                                if (r_bit_cnt >= 7'd3) r_sh_dlc <= w_dlc_full;
                                if (r_bit_cnt == 7'd6) begin
                                    r_bit_cnt   <= 7'd0;
                                    r_data_bits <= w_data_bits;
                                    r_state     <= (w_data_bits == 7'd0) ? S_CRC : S_DATA;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 7'd1;
                                end
                            end
                            S_DATA: begin
                                r_crc <= w_crc_next;
                                r_sh_data[6'd63 - r_bit_cnt[5:0]] <= w_bit;
                                if (r_bit_cnt == r_data_bits - 7'd1) begin
                                    r_state   <= S_CRC;
                                    r_bit_cnt <= 7'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 7'd1;
                                end
                            end
                            S_CRC: begin
                                r_crc_rx <= {r_crc_rx[13:0], w_bit};
                                if (r_bit_cnt == 7'd14) begin
                                    r_state   <= S_CRC_DEL;
                                    r_bit_cnt <= 7'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 7'd1;
                                end
                            end
                            S_CRC_DEL: begin
                                r_state   <= S_ACK;
                                r_bit_cnt <= 7'd0;
                            end
                            S_ACK: begin
                                if (r_bit_cnt == 7'd1) begin
                                    r_state   <= S_EOF;
                                    r_bit_cnt <= 7'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 7'd1;
                                end
                            end
                            S_EOF: begin
                                if (r_bit_cnt == 7'd6) begin
                                    address_rx <= r_sh_id;
                                    rx_dlc     <= r_sh_dlc;
                                    rx_rtr     <= r_sh_rtr;
                                    rx_data    <= r_sh_data;
                                    rx_valid   <= 1'b1;
                                    rxing      <= 1'b0;
                                    r_state    <= S_IDLE;
                                    r_bit_cnt  <= 7'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 7'd1;
                                end
                            end
                            default: r_state <= S_WAIT_IDLE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_block.sv
// Directed-plus-random bench for rx_block: frames are built and stuffed by a reference model in the bench.
// Latency: each line bit is held 4 clk and sampled by a baud_clk strobe 3 clk after the line change.
// Backpressure: not applicable; result strobes are sampled on the falling edge after each baud strobe.
module tb_rx_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        baud_clk;
    logic        can_rx;
    logic [10:0] address_rx;
    logic [3:0]  rx_dlc;
    logic        rx_rtr;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [2:0]  err_code;
    logic        rxing;

    always #5 clk = ~clk;

    rx_block dut (
        .clk        (clk),
        .rst        (rst),
        .baud_clk   (baud_clk),
        .can_rx     (can_rx),
        .address_rx (address_rx),
        .rx_dlc     (rx_dlc),
        .rx_rtr     (rx_rtr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .err_code   (err_code),
        .rxing      (rxing)
    );

    int n_vec = 0;
    int n_err = 0;

    // Line stream of the frame under test and positions of interesting bits in it.
    bit s_q[$];
    int g_upos[$];
    int pos_ide, pos_crc_last, pos_eof0;

    // Per-frame observations.
    int f_valid, f_err, f_vidx, f_eidx;
    logic f_sof_rxing;

    // Whole-run strobe accounting.
    int tot_v = 0, tot_e = 0, tot_both = 0;
    int exp_tv = 0, exp_te = 0;

    // Expected held outputs.
    logic [10:0] e_id;
    logic [3:0]  e_dlc;
    logic        e_rtr;
    logic [63:0] e_data;
    logic [2:0]  e_code;

    always @(negedge clk) begin
        if (rx_valid) tot_v++;
        if (rx_err) tot_e++;
        if (rx_valid && rx_err) tot_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the line bits of a standard frame. CRC is the remainder of the
    // polynomial division of message*x^15 by x^15+CRC_POLY; flip >= 0 inverts that CRC bit.
    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                               input logic [3:0] dlc, input logic [63:0] data, input int flip);
        bit u[$];
        logic [15:0] rem;
        logic [14:0] crc;
        int nb, cnt, nmsg;
        bit last, b;
        u.delete();
        u.push_back(1'b0);
        for (int i = 10; i >= 0; i--) u.push_back(id[i]);
        u.push_back(rtr);
        u.push_back(ide);
        u.push_back(1'b0);
        for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
        for (int k = 0; k < 8 * nb; k++) u.push_back(data[63 - k]);
        nmsg = u.size();
        rem = 16'd0;
        for (int i = 0; i < nmsg + 15; i++) begin
            b = (i < nmsg) ? u[i] : 1'b0;
            rem = {rem[14:0], b};
            if (rem[15]) rem = rem ^ 16'hC599;
        end
        crc = rem[14:0];
        for (int i = 14; i >= 0; i--) begin
            b = crc[i];
            if (14 - i == flip) b = !b;
            u.push_back(b);
        end
        s_q.delete();
        g_upos.delete();
        cnt = 0;
        last = 1'b0;
        for (int i = 0; i < u.size(); i++) begin
            if (i > 0 && cnt == 5) begin
                s_q.push_back(!last);
                last = !last;
                cnt = 1;
            end
            g_upos.push_back(s_q.size());
            s_q.push_back(u[i]);
            if (i > 0 && u[i] == last) cnt++;
            else begin
                cnt = 1;
                last = u[i];
            end
        end
        pos_ide = g_upos[13];
        pos_crc_last = g_upos[u.size() - 1];
        repeat (3) s_q.push_back(1'b1);
        pos_eof0 = s_q.size();
        repeat (7) s_q.push_back(1'b1);
    endtask

    task automatic send_bit(input bit b, input int idx);
        can_rx = b;
        repeat (3) @(negedge clk);
        baud_clk = 1'b1;
        @(negedge clk);
        baud_clk = 1'b0;
        if (rx_valid) begin f_valid++; f_vidx = idx; end
        if (rx_err) begin f_err++; f_eidx = idx; end
        if (idx == 0) f_sof_rxing = rxing;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, -1);
    endtask

    task automatic send_frame();
        f_valid = 0; f_err = 0; f_vidx = -1; f_eidx = -1; f_sof_rxing = 1'b0;
        for (int i = 0; i < s_q.size(); i++) send_bit(s_q[i], i);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_addr"}, 64'(address_rx), 64'(e_id));
        check({tag, "_dlc"},  64'(rx_dlc),     64'(e_dlc));
        check({tag, "_rtr"},  64'(rx_rtr),     64'(e_rtr));
        check({tag, "_data"}, rx_data,         e_data);
        check({tag, "_code"}, 64'(err_code),   64'(e_code));
        check({tag, "_rxing"}, 64'(rxing),     64'd0);
    endtask

    task automatic run_good(input string tag, input logic [10:0] id, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data);
        int nb;
        build_frame(id, rtr, 1'b0, dlc, data, -1);
        send_frame();
        nb = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
        e_id = id; e_rtr = rtr; e_dlc = dlc;
        e_data = (nb == 0) ? 64'd0 : (data & ({64{1'b1}} << (64 - 8 * nb)));
        exp_tv++;
        check({tag, "_vcnt"}, 64'(f_valid), 64'd1);
        check({tag, "_vidx"}, 64'(f_vidx), 64'(s_q.size() - 1));
        check({tag, "_ecnt"}, 64'(f_err), 64'd0);
        check({tag, "_sofrx"}, 64'(f_sof_rxing), 64'd1);
        check_held(tag);
    endtask

    task automatic run_err(input string tag, input logic [2:0] code, input int idx);
        send_frame();
        e_code = code;
        exp_te++;
        check({tag, "_ecnt"}, 64'(f_err), 64'd1);
        check({tag, "_eidx"}, 64'(f_eidx), 64'(idx));
        check({tag, "_vcnt"}, 64'(f_valid), 64'd0);
        check_held(tag);
    endtask

    task automatic run_ignored(input string tag);
        send_frame();
        check({tag, "_vcnt"}, 64'(f_valid), 64'd0);
        check({tag, "_ecnt"}, 64'(f_err), 64'd0);
        check_held(tag);
    endtask

    initial begin
        logic [10:0] rid;
        logic [3:0]  rdlc;
        logic        rrtr;
        logic [63:0] rdat;
        int          cut;

        rst = 1'b0; can_rx = 1'b1; baud_clk = 1'b0;
        e_id = '0; e_dlc = '0; e_rtr = 1'b0; e_data = '0; e_code = '0;
        repeat (4) @(negedge clk);
        check("rst_valid", 64'(rx_valid), 64'd0);
        check("rst_err", 64'(rx_err), 64'd0);
        check_held("rst");
        rst = 1'b1;
        @(negedge clk);

        // Bus integration, then the reference frames.
        idle(12);
        run_good("f123", 11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000);
        check("f123_lit", rx_data, 64'hABCD_0000_0000_0000);
        run_good("f000", 11'h000, 1'b0, 4'd8, 64'd0);

        // Random frames, alternately back-to-back and with a short gap.
        for (int k = 0; k < 8; k++) begin
            rid  = 11'($urandom);
            rrtr = ($urandom_range(0, 3) == 0);
            rdlc = 4'($urandom_range(0, 15));
            rdat = {$urandom, $urandom};
            run_good("rnd", rid, rrtr, rdlc, rdat);
            if (k % 2 == 1) idle($urandom_range(1, 3));
        end

        // Six dominant bits: SOF plus five ID zeros, then the missing stuff bit.
        s_q.delete();
        repeat (6) s_q.push_back(1'b0);
        run_err("stuff", 3'd1, 5);
        build_frame(11'h2A5, 1'b0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, -1);
        run_ignored("nointeg");
        idle(12);
        run_good("recov", 11'h2A5, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);

        build_frame(11'h456, 1'b0, 1'b0, 4'd3, 64'h1122_3300_0000_0000, 7);
        run_err("crc", 3'd2, pos_crc_last);
        idle(12);

        build_frame(11'h0F0, 1'b0, 1'b0, 4'd1, 64'h8100_0000_0000_0000, -1);
        s_q[pos_eof0 + 3] = 1'b0;
        run_err("eof4", 3'd3, pos_eof0 + 3);
        idle(12);

        build_frame(11'h3C3, 1'b0, 1'b1, 4'd2, 64'hFFFF_0000_0000_0000, -1);
        run_err("ide", 3'd4, pos_ide);
        idle(12);

        // Asynchronous reset in the middle of the payload.
        build_frame(11'h555, 1'b0, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, -1);
        cut = g_upos[19 + 20];
        f_valid = 0; f_err = 0;
        for (int i = 0; i < cut; i++) send_bit(s_q[i], i);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_vcnt", 64'(f_valid), 64'd0);
        check("rstmid_ecnt", 64'(f_err), 64'd0);
        e_id = '0; e_dlc = '0; e_rtr = 1'b0; e_data = '0; e_code = '0;
        check_held("rstmid");
        rst = 1'b1;
        @(negedge clk);
        build_frame(11'h321, 1'b0, 1'b0, 4'd2, 64'hBEEF_0000_0000_0000, -1);
        run_ignored("postrst");
        idle(12);
        run_good("rtr3", 11'h1A7, 1'b1, 4'd3, 64'hDEAD_BEEF_0000_0000);
        check("rtr3_lit", rx_data, 64'd0);

        repeat (4) @(negedge clk);
        check("tot_valid", 64'(tot_v), 64'(exp_tv));
        check("tot_err", 64'(tot_e), 64'(exp_te));
        check("tot_both", 64'(tot_both), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
